// File: rtl/stopwatch_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl_multi
// Brief    : Multi-mode stopwatch control core. Optional lap capture is built
//            when the macro STOPWATCH_LAP_EN is defined.
// Revision : 1.0
// ============================================================================
module stopwatch_ctrl_multi #(
  parameter int NUM_MODES = 2,
  parameter int CNT_W     = 16,
  parameter int STEP_BASE = 10,
  parameter int WRAP      = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NUM_MODES-1:0] start,
  input  logic                 pause,
  input  logic                 clr,
  input  logic                 tick,
`ifdef STOPWATCH_LAP_EN
  input  logic                 lap,
  output logic [CNT_W-1:0]     lap_count,
  output logic                 lap_valid,
`endif
  output logic [NUM_MODES-1:0] run_mode,
  output logic                 paused,
  output logic                 cleared,
  output logic [CNT_W-1:0]     count,
  output logic                 overflow
);

  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

  function automatic longint pow_step(input int k);
    longint p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * longint'(STEP_BASE);
    return p;
  endfunction

  generate
    if (NUM_MODES < 1 || NUM_MODES > 8) begin : g_mode_check
      $error("NUM_MODES must be in 1..8");
    end
    if (pow_step(NUM_MODES-1) >= (longint'(1) << CNT_W)) begin : g_step_check
      $error("STEP_BASE^(NUM_MODES-1) does not fit in CNT_W bits");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [MW-1:0]          r_mode, w_mode_nxt;
  logic [NUM_MODES-1:0]   r_start_q, w_start_edge;
  logic                   r_pause_q, r_clr_q;
  logic                   w_pause_edge, w_clr_edge, w_start_any;
  logic [MW-1:0]          w_sel;
  logic [CNT_W:0]         w_step, w_sum;
  logic [CNT_W-1:0]       w_count_nxt;
  logic                   w_ovf_nxt;

  // Edge registers start at all-ones so buttons held through reset stay inert.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_start_q <= '1;
      r_pause_q <= 1'b1;
      r_clr_q   <= 1'b1;
    end else begin
      r_start_q <= start;
      r_pause_q <= pause;
      r_clr_q   <= clr;
    end
  end

  assign w_start_edge = start & ~r_start_q;
  assign w_pause_edge = pause & ~r_pause_q;
  assign w_clr_edge   = clr & ~r_clr_q;
  assign w_start_any  = |w_start_edge;

  // Ascending scan: the highest pressed index overwrites lower ones.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_MODES; k++)
      if (w_start_edge[k]) w_sel = MW'(k);
  end

  always_comb begin
    w_step = '0;
    for (int k = 0; k < NUM_MODES; k++)
      if (int'(r_mode) == k) w_step = (CNT_W+1)'(pow_step(k));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_CLEAR;
      r_mode  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  // A pause edge only matters in RUN; elsewhere a coincident start still acts.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    run_mode    = '0;
    paused      = 1'b0;
    cleared     = 1'b0;
    if (w_clr_edge) begin
      w_state_nxt = S_CLEAR;
    end else if (w_pause_edge && r_state == S_RUN) begin
      w_state_nxt = S_PAUSE;
    end else if (w_start_any) begin
      w_state_nxt = S_RUN;
      w_mode_nxt  = w_sel;
    end
    if (r_state == S_RUN) run_mode = NUM_MODES'(1) << r_mode;
    paused  = (r_state == S_PAUSE);
    cleared = (r_state == S_CLEAR);
  end

  // Tick uses the mode in force before any coincident switch; clr overrides it.
  always_comb begin
    w_sum       = {1'b0, count} + w_step;
    w_count_nxt = count;
    w_ovf_nxt   = overflow;
    if (w_clr_edge) begin
      w_count_nxt = '0;
      w_ovf_nxt   = 1'b0;
    end else if (r_state == S_RUN && tick) begin
      if (w_sum[CNT_W]) begin
        w_ovf_nxt   = 1'b1;
        w_count_nxt = (WRAP != 0) ? w_sum[CNT_W-1:0] : '1;
      end else begin
        w_count_nxt = w_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= w_count_nxt;
      overflow <= w_ovf_nxt;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic r_lap_q;
  logic w_lap_edge;

  assign w_lap_edge = lap & ~r_lap_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_lap_q   <= 1'b1;
      lap_count <= '0;
      lap_valid <= 1'b0;
    end else begin
      r_lap_q <= lap;
      if (w_clr_edge) begin
        lap_count <= '0;
        lap_valid <= 1'b0;
      end else if (w_lap_edge && r_state != S_CLEAR) begin
        lap_count <= w_count_nxt;
        lap_valid <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl_multi
// Brief    : Scoreboard bench for stopwatch_ctrl_multi; a saturating and a
//            wrapping instance share stimulus, each against its own model.
// Revision : 1.0
// ============================================================================
module tb_stopwatch_ctrl_multi;

  localparam int NM = 2;
  localparam int CW = 8;
  localparam int SB = 10;
  localparam int ST_CLR = 0, ST_RUN = 1, ST_PAU = 2;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [NM-1:0] start = '0;
  logic          pause = 1'b0, clr = 1'b0, tick = 1'b0, lap = 1'b0;

  logic [NM-1:0] rm0, rm1;
  logic          pa0, pa1, cl0, cl1, ov0, ov1;
  logic [CW-1:0] cnt0, cnt1;
`ifdef STOPWATCH_LAP_EN
  logic [CW-1:0] lc0, lc1;
  logic          lv0, lv1;
`endif

  stopwatch_ctrl_multi #(.NUM_MODES(NM), .CNT_W(CW), .STEP_BASE(SB), .WRAP(0)) dut_sat (
    .clk(clk), .n_rst(n_rst), .start(start), .pause(pause), .clr(clr), .tick(tick),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_count(lc0), .lap_valid(lv0),
`endif
    .run_mode(rm0), .paused(pa0), .cleared(cl0), .count(cnt0), .overflow(ov0)
  );

  stopwatch_ctrl_multi #(.NUM_MODES(NM), .CNT_W(CW), .STEP_BASE(SB), .WRAP(1)) dut_wrap (
    .clk(clk), .n_rst(n_rst), .start(start), .pause(pause), .clr(clr), .tick(tick),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_count(lc1), .lap_valid(lv1),
`endif
    .run_mode(rm1), .paused(pa1), .cleared(cl1), .count(cnt1), .overflow(ov1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    int ovf;
    int run_mode;
    int paused;
    int cleared;
    int lap_count;
    int lap_valid;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index 0 saturates, index 1 wraps.
  int m_state[2], m_mode[2], m_count[2], m_ovf[2], m_lap[2], m_lapv[2];
  int m_prev_start, m_prev_pause, m_prev_clr, m_prev_lap;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit rst_on, input int s, input int p,
                              input int c, input int t, input int l);
    int se, pe, ce, le, sum, nc, no;
    if (rst_on) begin
      for (int w = 0; w < 2; w++) begin
        m_state[w] = ST_CLR; m_mode[w] = 0; m_count[w] = 0;
        m_ovf[w] = 0; m_lap[w] = 0; m_lapv[w] = 0;
      end
      m_prev_start = (1 << NM) - 1;
      m_prev_pause = 1; m_prev_clr = 1; m_prev_lap = 1;
      return;
    end
    se = s & ~m_prev_start & ((1 << NM) - 1);
    pe = p & ~m_prev_pause & 1;
    ce = c & ~m_prev_clr & 1;
    le = l & ~m_prev_lap & 1;
    for (int w = 0; w < 2; w++) begin
      nc = m_count[w];
      no = m_ovf[w];
      if (m_state[w] == ST_RUN && t != 0) begin
        sum = m_count[w] + SB ** m_mode[w];
        if (sum >= 2 ** CW) begin
          nc = (w == 1) ? sum % (2 ** CW) : 2 ** CW - 1;
          no = 1;
        end else begin
          nc = sum;
        end
      end
      if (ce != 0) begin
        m_state[w] = ST_CLR;
        nc = 0; no = 0; m_lap[w] = 0; m_lapv[w] = 0;
      end else begin
        if (le != 0 && m_state[w] != ST_CLR) begin
          m_lap[w] = nc; m_lapv[w] = 1;
        end
        if (pe != 0 && m_state[w] == ST_RUN) begin
          m_state[w] = ST_PAU;
        end else if (se != 0) begin
          m_state[w] = ST_RUN;
          m_mode[w]  = $clog2(se + 1) - 1;
        end
      end
      m_count[w] = nc;
      m_ovf[w]   = no;
    end
    m_prev_start = s; m_prev_pause = p; m_prev_clr = c; m_prev_lap = l;
  endtask

  function automatic exp_t model_exp(input int w);
    exp_t e;
    e.count     = m_count[w];
    e.ovf       = m_ovf[w];
    e.run_mode  = (m_state[w] == ST_RUN) ? (1 << m_mode[w]) : 0;
    e.paused    = (m_state[w] == ST_PAU) ? 1 : 0;
    e.cleared   = (m_state[w] == ST_CLR) ? 1 : 0;
    e.lap_count = m_lap[w];
    e.lap_valid = m_lapv[w];
    return e;
  endfunction

  // One cycle of stimulus: drive on the falling edge, predict the next rising edge.
  task automatic drive(input logic [NM-1:0] s, input logic p, input logic c,
                       input logic t, input logic l, input logic rst_on);
    @(negedge clk);
    start = s; pause = p; clr = c; tick = t; lap = l;
    n_rst = ~rst_on;
    model_update(rst_on, int'(s), int'(p), int'(c), int'(t), int'(l));
    q0.push_back(model_exp(0));
    q1.push_back(model_exp(1));
  endtask

  task automatic check_dut(input string tag, input exp_t e, input int cnt, input int ov,
                           input int rm, input int pa, input int cl);
    chk({tag, "_count"}, cnt, e.count);
    chk({tag, "_overflow"}, ov, e.ovf);
    chk({tag, "_run_mode"}, rm, e.run_mode);
    chk({tag, "_paused"}, pa, e.paused);
    chk({tag, "_cleared"}, cl, e.cleared);
  endtask

  // Monitor: every rising edge presents a new output word from each instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check_dut("sat", e, int'(cnt0), int'(ov0), int'(rm0), int'(pa0), int'(cl0));
`ifdef STOPWATCH_LAP_EN
        chk("sat_lap_count", int'(lc0), e.lap_count);
        chk("sat_lap_valid", int'(lv0), e.lap_valid);
`endif
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check_dut("wrap", e, int'(cnt1), int'(ov1), int'(rm1), int'(pa1), int'(cl1));
`ifdef STOPWATCH_LAP_EN
        chk("wrap_lap_count", int'(lc1), e.lap_count);
        chk("wrap_lap_valid", int'(lv1), e.lap_valid);
`endif
      end
    end
  end

  initial begin
    logic [NM-1:0] rs;
    logic rp, rc, rt, rl, rr;

    repeat (2) drive('0, 0, 0, 0, 0, 1);
    drive('0, 0, 0, 0, 0, 0);

    // Start mode 0, five ticks, then live switch to mode 1 with a coincident tick.
    drive(2'b01, 0, 0, 0, 0, 0);
    repeat (5) drive('0, 0, 0, 1, 0, 0);
    drive(2'b10, 0, 0, 1, 0, 0);
    repeat (3) drive('0, 0, 0, 1, 0, 0);

    // Pause holds the count; resume in mode 0.
    drive('0, 1, 0, 0, 0, 0);
    repeat (4) drive('0, 0, 0, 1, 0, 0);
    drive(2'b01, 0, 0, 0, 0, 0);
    drive('0, 0, 0, 1, 0, 0);

    // Clear, run mode 1 up to 250, then cross the limit twice.
    drive('0, 0, 1, 0, 0, 0);
    drive('0, 0, 0, 0, 0, 0);
    drive(2'b10, 0, 0, 0, 0, 0);
    repeat (25) drive('0, 0, 0, 1, 0, 0);
    repeat (2) drive('0, 0, 0, 1, 0, 0);

    // Clear beats a coincident tick and pause.
    drive('0, 1, 1, 1, 0, 0);

    // Lap capture at 20 with a coincident tick, then clear.
    drive('0, 0, 0, 0, 0, 0);
    drive(2'b01, 0, 0, 0, 0, 0);
    repeat (20) drive('0, 0, 0, 1, 0, 0);
    drive('0, 0, 0, 1, 1, 0);
    repeat (4) drive('0, 0, 0, 1, 0, 0);
    drive('0, 0, 1, 0, 0, 0);

    // Start held through reset release is ignored until re-pressed.
    repeat (2) drive(2'b01, 0, 0, 0, 0, 1);
    repeat (3) drive(2'b01, 0, 0, 1, 0, 0);
    drive('0, 0, 0, 0, 0, 0);
    drive(2'b01, 0, 0, 0, 0, 0);
    repeat (3) drive('0, 0, 0, 1, 0, 0);

    // Asynchronous reset in the middle of a run.
    drive('0, 0, 0, 1, 0, 1);
    drive('0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      rs = ($urandom_range(0, 5) == 0) ? NM'($urandom_range(0, (1 << NM) - 1)) : '0;
      rp = ($urandom_range(0, 7) == 0);
      rc = ($urandom_range(0, 39) == 0);
      rt = ($urandom_range(0, 1) == 1);
      rl = ($urandom_range(0, 9) == 0);
      rr = ($urandom_range(0, 199) == 0);
      drive(rs, rp, rc, rt, rl, rr);
    end

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drain", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl_multi.md
Name: stopwatch_ctrl_multi

Overview:
- Parametrised stopwatch control core with NUM_MODES run modes; mode k advances the elapsed count by STEP_BASE^k per tick.
- Combines rising-edge detection on button inputs, a CLEAR/RUN/PAUSE state machine with live mode switching, and a saturating or wrapping elapsed counter with a sticky overflow flag.
- Sits between the debounced button block and the display/BCD formatter; the tick strobe comes from the shared prescaler.

Parameters:
- NUM_MODES, 2, number of run modes / start buttons (1..8).
- CNT_W, 16, elapsed count width; STEP_BASE^(NUM_MODES-1) must be < 2^CNT_W (checked at elaboration).
- STEP_BASE, 10, per-mode step base; mode k step = STEP_BASE^k.
- WRAP, 0, 0 = saturate at 2^CNT_W-1, 1 = wrap modulo 2^CNT_W.

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous, active-low reset
- start  in  NUM_MODES  level start buttons; bit k selects mode k
- pause  in  1  level pause button
- clr  in  1  level clear button
- tick  in  1  one-cycle count strobe from prescaler
- run_mode  out  NUM_MODES  one-hot active mode, all zero unless in RUN
- paused  out  1  state == PAUSE
- cleared  out  1  state == CLEAR
- count  out  CNT_W  elapsed count, registered
- overflow  out  1  sticky: count limit exceeded since last clear

Behaviour:
- Reset values: state CLEAR, mode index 0, count 0, overflow 0, run_mode 0, paused 0, cleared 1, lap_count 0 (if enabled).
- Button edge registers reset to all-ones, so a button held through reset release is ignored until it is released and pressed again.
- Edge = input & ~previous-cycle sample. Only edges act; held levels do nothing.
- Multiple start edges in one cycle: the highest index wins.
- Event priority in any state: clr edge > pause edge > start edge.
- CLEAR:
  - start edge k -> RUN, mode = k.
  - pause edge ignored.
- RUN:
  - clr edge -> CLEAR.
  - pause edge -> PAUSE.
  - start edge j -> stay in RUN, mode = j. Same-mode re-press is a no-op.
- PAUSE:
  - clr edge -> CLEAR.
  - start edge k -> RUN, mode = k.
  - pause edge ignored.
- All state and output changes take effect at the clock edge that samples the button edge: 1-cycle latency from the input rising to the output change.
- Counting:
  - When the current state is RUN and tick = 1, count <= count + STEP_BASE^mode, computed in CNT_W+1 bits.
  - A tick in the same cycle as a pause or mode-switch edge is still counted, using the old mode.
  - A tick in PAUSE or CLEAR is ignored.
- Limit handling: if the sum is >= 2^CNT_W:
  - WRAP=0: count = 2^CNT_W-1.
  - WRAP=1: count = sum mod 2^CNT_W.
  - In both cases overflow <= 1.
  - While saturated, further ticks hold the value.
- A clr edge clears count and overflow in the same edge as the state moves to CLEAR. This overrides a coincident tick.
- Asynchronous reset mid-run returns immediately to the reset values.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - Adds input lap (level), output lap_count [CNT_W-1:0] and output lap_valid (1 bit).
  - A lap edge in RUN or PAUSE captures the value count would take after this edge into lap_count and sets lap_valid.
  - A lap edge in CLEAR is ignored.
  - A clr edge zeroes lap_count and lap_valid.
  - A lap edge shares its edge-detect register scheme with the other buttons (reset to 1).
- Undefined: the lap ports are absent and there is no lap logic.

Test Plan (NUM_MODES=2, STEP_BASE=10, CNT_W=8 unless noted):
- Reset, start=01 for 1 cycle, then 5 ticks -> run_mode=01, count=5, cleared=0.
- From count=5 in mode 0, start=10 edge with tick in the same cycle -> count=6, run_mode=10; 3 more ticks -> count=36.
- Pause edge, 4 ticks -> count holds 36, paused=1, run_mode=00. Then start=01 edge plus 1 tick -> count=37, run_mode=01.
- WRAP=0, count=250, mode 1, tick -> count=255, overflow=1; another tick -> 255. With WRAP=1 from 250 -> count=4, overflow=1.
- clr edge coincident with tick and pause edge -> count=0, overflow=0, cleared=1. A start button held through reset release -> stays in CLEAR until released and re-pressed.
- STOPWATCH_LAP_EN: at count=20 in RUN, lap edge with tick (mode 0) -> lap_count=21, lap_valid=1; count continues to 25 while lap_count stays 21; clr -> lap_count=0, lap_valid=0.
